if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_pkg.sv | 39 +++
 rtl/if_fetch_fifo.sv | 72 +++++++
 rtl/if_fetch.sv | 128 ++++++++++++
 tb/tb_if_fetch.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_pkg
// Shared constants and types for the instruction fetch unit.
//   XLEN        : address / instruction width
//   ZERO_WORD   : all-zero word driven on idle outputs
//   OPC_JAL     : opcode recognised by the optional predecoder
//   fetch_state_e, fetch_entry_t : FSM encoding and buffer entry layout
//   jal_imm()   : sign-extended J-type immediate
//   word_align(): clears address bits [1:0]
// ---------------------------------------------------------------------------
package if_fetch_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [6:0]  OPC_JAL   = 7'b1101111;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            pred;
    } fetch_entry_t;

    // imm[20|10:1|11|19:12] scattered across inst[31:12]; bit 0 is implicit zero.
    function automatic logic [XLEN-1:0] jal_imm(input logic [XLEN-1:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding fetched entries until decode takes them.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i/wdata_i: write an entry (ignored when full unless popping too)
//   pop_i         : remove the head entry (ignored when empty)
//   flush_i       : drop every entry; has priority over push/pop
//   full_o/empty_o: occupancy flags
//   rdata_o       : head entry, forced to zero while empty
// DEPTH must be a power of two (2..8).
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] rdata_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A push into a full buffer is legal only when the head leaves the same edge.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: the read side is masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
// Instruction fetch stage: issues word-aligned requests to instruction
// memory, buffers {pc, inst, pred} entries and presents the head to decode.
//   CLK, RST_N                  : clock, synchronous active-low reset
//   mem_req/mem_addr            : fetch request and address (out)
//   mem_ready/mem_inst          : memory accept + returned word (in)
//   redirect_valid/redirect_pc  : flush and restart at a new pc (in)
//   out_valid/out_ready         : decode handshake
//   out_pc/out_inst/out_pred_taken : head entry contents
//   dbg_state                   : current FSM state for observation
// Handshakes: a transfer happens on a rising edge where valid (req) and
// ready are both high; valid/req never depend on ready of the same channel
// except that mem_req may rise when decode frees a slot that cycle.
// Optional feature: define FETCH_PREDECODE_EN to follow JAL targets at
// accept time and mark the entry as predicted taken.
// ---------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         CLK,
    input  logic         RST_N,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_ready,
    input  logic [31:0]  mem_inst,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_pc,
    output logic [31:0]  out_inst,
    output logic         out_pred_taken,
    output fetch_state_e dbg_state
);

    localparam int EW = $bits(fetch_entry_t);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] seq_pc;
    logic            is_jal;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            accept;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;
    logic [EW-1:0]   head_bits;

    // Predecode decides where the next fetch goes once this word is accepted.
`ifdef FETCH_PREDECODE_EN
    assign is_jal = (mem_inst[6:0] == OPC_JAL);
    assign seq_pc = is_jal ? word_align(pc_q + jal_imm(mem_inst)) : pc_q + PC_STEP;
`else
    assign is_jal = 1'b0;
    assign seq_pc = pc_q + PC_STEP;
`endif

    // Outputs are masked during reset so nothing stale leaks out.
    assign out_valid = RST_N && !fifo_empty;
    assign pop       = out_valid && out_ready;
    // A slot counts as free if the head is leaving this same cycle.
    assign mem_req   = RST_N && (state_q != ST_BOOT) && !redirect_valid
                       && (!fifo_full || pop);
    assign mem_addr  = RST_N ? pc_q : word_align(RESET_PC);
    assign accept    = mem_req && mem_ready;

    assign push_entry = '{pc: pc_q, inst: mem_inst, pred: is_jal};

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .push_i  (accept),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .rdata_o (head_bits)
    );

    assign head_entry     = fetch_entry_t'(head_bits);
    assign out_pc         = out_valid ? head_entry.pc   : ZERO_WORD;
    assign out_inst       = out_valid ? head_entry.inst : ZERO_WORD;
    assign out_pred_taken = out_valid && head_entry.pred;
    assign dbg_state      = state_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            // Any response arriving this cycle is dropped: accept is low.
            state_d = ST_RUN;
            pc_d    = word_align(redirect_pc);
        end else begin
            case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_RUN, ST_WAIT: begin
                    if (mem_req) begin
                        state_d = mem_ready ? ST_RUN : ST_WAIT;
                    end
                    if (accept) begin
                        pc_d = seq_pc;
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_BOOT;
            pc_q    <= word_align(RESET_PC);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch
// Directed scenarios followed by a randomized run, all checked against a
// queue-based reference model of the fetch unit.
// ---------------------------------------------------------------------------
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ready;
    logic [31:0]  mem_inst;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_pc;
    logic [31:0]  out_inst;
    logic         out_pred_taken;
    fetch_state_e dbg_state;

    if_fetch #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_inst       (mem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_pred_taken (out_pred_taken),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- scoreboard / model ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [64:0] exp_q[$];      // {pc, inst, pred}
    logic [31:0] m_pc;
    bit          m_boot;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_is_jal(input logic [31:0] inst);
`ifdef FETCH_PREDECODE_EN
        return inst[6:0] == 7'h6F;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_next_pc(input logic [31:0] pc, input logic [31:0] inst);
        logic [31:0] imm;
        if (model_is_jal(inst)) begin
            imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            return (pc + imm) & 32'hFFFF_FFFC;
        end
        return pc + 32'd4;
    endfunction

    // One clock cycle: compare all outputs at the falling edge, advance the
    // model with the inputs held for this cycle, then return 1 after the edge.
    task automatic step();
        logic        e_req;
        logic        e_val;
        logic [64:0] head;
        @(negedge CLK);
        e_val = RST_N && (exp_q.size() > 0);
        head  = e_val ? exp_q[0] : 65'd0;
        e_req = RST_N && !m_boot && !redirect_valid
                && ((exp_q.size() < DEPTH) || (e_val && out_ready));
        check("mem_req",   {31'd0, mem_req},        {31'd0, e_req});
        check("mem_addr",  mem_addr,                RST_N ? m_pc : RST_PC);
        check("out_valid", {31'd0, out_valid},      {31'd0, e_val});
        check("out_pc",    out_pc,                  head[64:33]);
        check("out_inst",  out_inst,                head[32:1]);
        check("out_pred",  {31'd0, out_pred_taken}, {31'd0, head[0]});
        if (!RST_N) begin
            m_pc   = RST_PC;
            m_boot = 1'b1;
            exp_q.delete();
        end else if (redirect_valid) begin
            exp_q.delete();
            m_pc   = redirect_pc & 32'hFFFF_FFFC;
            m_boot = 1'b0;
        end else begin
            m_boot = 1'b0;
            if (e_val && out_ready) void'(exp_q.pop_front());
            if (e_req && mem_ready) begin
                exp_q.push_back({m_pc, mem_inst, model_is_jal(mem_inst)});
                m_pc = model_next_pc(m_pc, mem_inst);
            end
        end
        @(posedge CLK);
        #1;
        mem_inst = $urandom();
    endtask

    task automatic reset_dut();
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        step();  // boot cycle
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST_N          = 1'b0;
        mem_ready      = 1'b0;
        mem_inst       = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b0;
        m_pc           = RST_PC;
        m_boot         = 1'b1;
        @(posedge CLK);
        #1;
        repeat (2) step();
        #1;
        check("rst_mem_req",   {31'd0, mem_req},        32'd0);
        check("rst_mem_addr",  mem_addr,                RST_PC);
        check("rst_out_valid", {31'd0, out_valid},      32'd0);
        check("rst_out_pc",    out_pc,                  32'd0);
        check("rst_out_inst",  out_inst,                32'd0);
        check("rst_out_pred",  {31'd0, out_pred_taken}, 32'd0);

        // streaming with both sides always ready
        RST_N = 1'b1; mem_ready = 1'b1; out_ready = 1'b1;
        step();
        #1 check("stream_addr0", mem_addr, 32'd0);
        check("stream_req", {31'd0, mem_req}, 32'd1);
        step();
        #1 check("stream_addr4", mem_addr, 32'd4);
        check("stream_head0", out_pc, 32'd0);
        step();
        #1 check("stream_addr8", mem_addr, 32'd8);
        check("stream_head4", out_pc, 32'd4);
        step();

        // decode stalled: buffer fills, request drops and address holds
        out_ready = 1'b0;
        reset_dut();
        step();
        step();
        #1 check("full_req_low", {31'd0, mem_req}, 32'd0);
        check("full_addr8", mem_addr, 32'd8);
        check("full_head0", out_pc, 32'd0);
        step();
        step();
        #1 check("full_hold_addr8", mem_addr, 32'd8);
        out_ready = 1'b1;
        #1 check("full_pop_push_req", {31'd0, mem_req}, 32'd1);
        step();
        #1 check("full_head4", out_pc, 32'd4);
        step();

        // memory stall at address 8
        reset_dut();
        step();
        step();
        mem_ready = 1'b0;
        repeat (3) begin
            #1 check("wait_req", {31'd0, mem_req}, 32'd1);
            check("wait_addr8", mem_addr, 32'd8);
            step();
        end
        mem_ready = 1'b1;
        step();
        #1 check("wait_head8", out_pc, 32'd8);
        step();
        #1 check("wait_head12", out_pc, 32'd12);

        // reset while waiting: the pending response is abandoned
        mem_ready = 1'b0;
        step();
        RST_N = 1'b0; mem_ready = 1'b1;
        step();
        RST_N = 1'b1;
        step();
        #1 check("abandon_empty", {31'd0, out_valid}, 32'd0);

        // redirect with two entries buffered
        out_ready = 1'b0;
        step();
        step();
        #1 check("redir_pre_valid", {31'd0, out_valid}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        #1 check("redir_flushed", {31'd0, out_valid}, 32'd0);
        check("redir_addr", mem_addr, 32'h0000_0100);

        // JAL at pc 4
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0004;
        step();
        redirect_valid = 1'b0; out_ready = 1'b1; mem_inst = 32'h0100_006F;
        #1 check("jal_addr4", mem_addr, 32'h4);
        step();
`ifdef FETCH_PREDECODE_EN
        #1 check("jal_next_addr", mem_addr, 32'h14);
        check("jal_pred", {31'd0, out_pred_taken}, 32'd1);
`else
        #1 check("jal_next_addr", mem_addr, 32'h8);
        check("jal_pred", {31'd0, out_pred_taken}, 32'd0);
`endif
        check("jal_head_pc", out_pc, 32'h4);

        // wrap-around at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0; mem_inst = 32'h0000_0013;
        #1 check("wrap_addr_top", mem_addr, 32'hFFFF_FFFC);
        step();
        #1 check("wrap_addr_zero", mem_addr, 32'h0000_0000);
        check("wrap_head", out_pc, 32'hFFFF_FFFC);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            mem_ready      = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 31) == 0);
            redirect_pc    = $urandom();
            RST_N          = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
